cipher_stream_adapter: RTL and testbench

- Byte-side front end for dual_xor_stream_cipher, sitting directly on its bit-serial ports.
- Loads the M-bit key through the cipher's cfg shift chain (cfg_en/cfg_i).
- Serialises outgoing bytes onto tx_p/tx_en and forwards incoming line bits onto rx_e/rx_en.
- Reassembles the cipher's rx_p plaintext bits into bytes, so host logic works in bytes with a valid/ready handshake.

---
 rtl/cipher_stream_adapter_if.sv | 38 +++
 rtl/cipher_stream_adapter.sv | 182 ++++++++++++++++++
 tb/tb_cipher_stream_adapter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cipher_stream_adapter_if.sv
// Byte-side and bit-serial signal bundle for cipher_stream_adapter.
// master = host/cipher side driving the adapter; slave = the adapter itself.
interface cipher_stream_adapter_if #(
  parameter int M = 32,
  parameter int W = 8
);
  logic [M-1:0] key;
  logic         key_load;
  logic         key_busy;
  logic         cfg_en;
  logic         cfg_i;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_p;
  logic         tx_en;
  logic         rx_bit;
  logic         rx_bit_valid;
  logic         rx_flush;
  logic         rx_e;
  logic         rx_en;
  logic         rx_p;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_drop;

  modport master (
    output key, key_load, tx_data, tx_valid, rx_bit, rx_bit_valid, rx_flush, rx_p,
    input  key_busy, cfg_en, cfg_i, tx_ready, tx_p, tx_en, rx_e, rx_en, rx_data,
           rx_valid, rx_drop
  );

  modport slave (
    input  key, key_load, tx_data, tx_valid, rx_bit, rx_bit_valid, rx_flush, rx_p,
    output key_busy, cfg_en, cfg_i, tx_ready, tx_p, tx_en, rx_e, rx_en, rx_data,
           rx_valid, rx_drop
  );
endinterface

// File: rtl/cipher_stream_adapter.sv
// Byte-side front end for a bit-serial stream cipher: key load over the cfg chain,
// tx word serialiser, rx line forwarding and plaintext byte reassembly.
module cipher_stream_adapter #(
  parameter int M      = 32,
  parameter int W      = 8,
  parameter int RX_LAT = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  cipher_stream_adapter_if.slave if_s
);

  localparam int MAXB = (M > W) ? M : W;
  localparam int CW   = $clog2(MAXB);
  localparam int RCW  = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, TX_SHIFT, KEY_SHIFT} state_t;

  state_t         r_state, w_state_nx;
  logic [CW-1:0]  r_cnt, w_cnt_nx;
  logic [W-1:0]   r_tx_sr, w_tx_sr_nx;
  logic [M-1:0]   r_key_sr, w_key_sr_nx;
  logic           r_key_pend, w_key_pend_nx;
  logic           r_key_busy, w_key_busy_nx;
  logic           r_tx_ready, w_tx_ready_nx;
  logic           r_tx_en, w_tx_en_nx;
  logic           r_tx_p, w_tx_p_nx;
  logic           r_cfg_en, w_cfg_en_nx;
  logic           r_cfg_i, w_cfg_i_nx;
  logic           w_key_acc;

  logic           r_rx_e, r_rx_en, r_rx_drop, r_rx_valid;
  logic [W-2:0]   r_rx_asm;
  logic [W-1:0]   r_rx_data;
  logic [RCW-1:0] r_rx_cnt;
  logic [RX_LAT-1:0] r_dly;
  logic [W-1:0]   w_rx_word;

  assign w_key_acc = if_s.key_load && !r_key_busy;
  assign w_rx_word = {r_rx_asm, if_s.rx_p};

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_tx_sr_nx    = r_tx_sr;
    w_key_sr_nx   = r_key_sr;
    w_key_pend_nx = r_key_pend;
    w_key_busy_nx = r_key_busy;
    w_tx_en_nx    = 1'b0;
    w_tx_p_nx     = 1'b0;
    w_cfg_en_nx   = 1'b0;
    w_cfg_i_nx    = 1'b0;
    w_tx_ready_nx = 1'b0;

    if (w_key_acc) begin
      w_key_sr_nx   = if_s.key;
      w_key_pend_nx = 1'b1;
      w_key_busy_nx = 1'b1;
    end

    unique case (r_state)
      IDLE: begin
        // A pending key always wins over a new tx word offered in the same cycle
        if (r_key_pend) begin
          w_state_nx    = KEY_SHIFT;
          w_key_pend_nx = 1'b0;
          w_cfg_en_nx   = 1'b1;
          w_cfg_i_nx    = r_key_sr[M-1];
          w_key_sr_nx   = r_key_sr << 1;
          w_cnt_nx      = CW'(M - 1);
        end else if (if_s.tx_valid && r_tx_ready) begin
          w_state_nx = TX_SHIFT;
          w_tx_en_nx = 1'b1;
          w_tx_p_nx  = if_s.tx_data[W-1];
          w_tx_sr_nx = if_s.tx_data << 1;
          w_cnt_nx   = CW'(W - 1);
        end
      end
      TX_SHIFT: begin
        if (r_cnt == '0) begin
          w_state_nx = IDLE;
        end else begin
          w_tx_en_nx = 1'b1;
          w_tx_p_nx  = r_tx_sr[W-1];
          w_tx_sr_nx = r_tx_sr << 1;
          w_cnt_nx   = r_cnt - 1'b1;
        end
      end
      KEY_SHIFT: begin
        if (r_cnt == '0) begin
          w_state_nx    = IDLE;
          w_key_busy_nx = 1'b0;
        end else begin
          w_cfg_en_nx = 1'b1;
          w_cfg_i_nx  = r_key_sr[M-1];
          w_key_sr_nx = r_key_sr << 1;
          w_cnt_nx    = r_cnt - 1'b1;
        end
      end
      default: w_state_nx = IDLE;
    endcase

    w_tx_ready_nx = (w_state_nx == IDLE) && !w_key_pend_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_tx_sr    <= '0;
      r_key_sr   <= '0;
      r_key_pend <= 1'b0;
      r_key_busy <= 1'b0;
      r_tx_ready <= 1'b0;
      r_tx_en    <= 1'b0;
      r_tx_p     <= 1'b0;
      r_cfg_en   <= 1'b0;
      r_cfg_i    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_tx_sr    <= w_tx_sr_nx;
      r_key_sr   <= w_key_sr_nx;
      r_key_pend <= w_key_pend_nx;
      r_key_busy <= w_key_busy_nx;
      r_tx_ready <= w_tx_ready_nx;
      r_tx_en    <= w_tx_en_nx;
      r_tx_p     <= w_tx_p_nx;
      r_cfg_en   <= w_cfg_en_nx;
      r_cfg_i    <= w_cfg_i_nx;
    end
  end

  // r_dly mirrors rx_en delayed to line up with the cipher's rx_p latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_e     <= 1'b0;
      r_rx_en    <= 1'b0;
      r_rx_drop  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_asm   <= '0;
      r_rx_data  <= '0;
      r_rx_cnt   <= '0;
      r_dly      <= '0;
    end else begin
      r_rx_e     <= if_s.rx_bit;
      r_rx_en    <= if_s.rx_bit_valid & ~r_key_busy;
      r_rx_drop  <= if_s.rx_bit_valid & r_key_busy;
      r_rx_valid <= 1'b0;
      if (if_s.rx_flush) begin
        r_rx_cnt <= '0;
        r_dly    <= '0;
      end else begin
        r_dly[0] <= r_rx_en;
        for (int i = 1; i < RX_LAT; i++) r_dly[i] <= r_dly[i-1];
        if (r_dly[RX_LAT-1]) begin
          r_rx_asm <= w_rx_word[W-2:0];
          if (r_rx_cnt == RCW'(W - 1)) begin
            r_rx_data  <= w_rx_word;
            r_rx_valid <= 1'b1;
            r_rx_cnt   <= '0;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign if_s.key_busy = r_key_busy;
  assign if_s.cfg_en   = r_cfg_en;
  assign if_s.cfg_i    = r_cfg_i;
  assign if_s.tx_ready = r_tx_ready;
  assign if_s.tx_en    = r_tx_en;
  assign if_s.tx_p     = r_tx_p;
  assign if_s.rx_e     = r_rx_e;
  assign if_s.rx_en    = r_rx_en;
  assign if_s.rx_drop  = r_rx_drop;
  assign if_s.rx_valid = r_rx_valid;
  assign if_s.rx_data  = r_rx_data;

endmodule

// File: tb/tb_cipher_stream_adapter.sv
// Scoreboard bench for cipher_stream_adapter: drivers push expected bits/words into
// queues, a negedge monitor pops and compares whatever the DUT presents.
module tb_cipher_stream_adapter;
  localparam int M = 32;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cipher_stream_adapter_if #(.M(M), .W(W)) bus ();

  cipher_stream_adapter #(.M(M), .W(W), .RX_LAT(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .if_s (bus.slave)
  );

  // Cipher stand-in: rx_p is the registered rx_e, one cycle of latency
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rx_p <= 1'b0;
    else        bus.rx_p <= bus.rx_e;
  end

  int n_chk = 0;
  int n_pass = 0;
  logic q_tx[$];
  logic q_cfg[$];
  logic [W-1:0] q_rx[$];
  logic m_bits[$];
  int exp_drop = 0, exp_fwd = 0, got_drop = 0, got_fwd = 0;
  int tx_run = 0, cfg_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: condition not met at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      tx_run  = 0;
      cfg_run = 0;
    end else begin
      if (bus.tx_en) begin
        tx_run++;
        check("tx_ready_low_during_word", bus.tx_ready, 0);
        if (q_tx.size() == 0) fail_now("tx_unexpected_bit");
        else check("tx_p", bus.tx_p, q_tx.pop_front());
      end else if (tx_run != 0) begin
        check("tx_en_len", tx_run, W);
        tx_run = 0;
      end
      if (bus.cfg_en) begin
        cfg_run++;
        check("cfg_tx_overlap", bus.tx_en, 0);
        check("busy_during_cfg", bus.key_busy, 1);
        if (q_cfg.size() == 0) fail_now("cfg_unexpected_bit");
        else check("cfg_i", bus.cfg_i, q_cfg.pop_front());
      end else if (cfg_run != 0) begin
        check("cfg_en_len", cfg_run, M);
        check("busy_fall_with_cfg", bus.key_busy, 0);
        cfg_run = 0;
      end
      if (bus.rx_en)   got_fwd++;
      if (bus.rx_drop) got_drop++;
      if (bus.rx_valid) begin
        if (q_rx.size() == 0) fail_now("rx_unexpected_word");
        else check("rx_data", bus.rx_data, q_rx.pop_front());
      end
    end
  end

  task automatic send_word(input logic [W-1:0] d, output logic busy_acc);
    int n;
    n = 0;
    busy_acc = 1'b0;
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_ready) fail_now("tx_accept_timeout");
    else begin
      busy_acc = bus.key_busy;
      for (int i = W - 1; i >= 0; i--) q_tx.push_back(d[i]);
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic load_key(input logic [M-1:0] k);
    logic acc;
    @(negedge clk);
    bus.key      = k;
    bus.key_load = 1'b1;
    acc = !bus.key_busy;
    if (acc) for (int i = M - 1; i >= 0; i--) q_cfg.push_back(k[i]);
    @(negedge clk);
    bus.key_load = 1'b0;
    if (acc) check("busy_rise", bus.key_busy, 1);
  endtask

  task automatic rx_send(input logic b);
    logic [W-1:0] w;
    @(negedge clk);
    bus.rx_bit       = b;
    bus.rx_bit_valid = 1'b1;
    if (bus.key_busy) exp_drop++;
    else begin
      exp_fwd++;
      m_bits.push_back(b);
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) w[W-1-i] = m_bits[i];
        q_rx.push_back(w);
        m_bits.delete();
      end
    end
  endtask

  task automatic rx_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rx_bit_valid = 1'b0;
    end
  endtask

  task automatic rx_flush_pulse();
    @(negedge clk);
    bus.rx_bit_valid = 1'b0;
    bus.rx_flush     = 1'b1;
    m_bits.delete();
    @(negedge clk);
    bus.rx_flush = 1'b0;
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((bus.key_busy || bus.tx_en || q_tx.size() != 0 || q_cfg.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail_now("quiet_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {bus.tx_ready, bus.tx_en, bus.tx_p, bus.cfg_en, bus.cfg_i,
                            bus.key_busy, bus.rx_e, bus.rx_en, bus.rx_valid, bus.rx_drop}, 0);
    check({name, "_rx_data"}, bus.rx_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic busy;
    logic [7:0] bits3c;
    logic [7:0] bits81;
    bus.key = '0; bus.key_load = 1'b0; bus.tx_data = '0; bus.tx_valid = 1'b0;
    bus.rx_bit = 1'b0; bus.rx_bit_valid = 1'b0; bus.rx_flush = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    #1 check("tx_ready_before_edge", bus.tx_ready, 0);
    @(negedge clk);
    check("tx_ready_after_reset", bus.tx_ready, 1);

    // Single word 0xA5 on the first ready cycle
    send_word(8'hA5, busy);
    repeat (W) @(negedge clk);
    check("tx_en_low_after_word", bus.tx_en, 0);
    check("tx_ready_back", bus.tx_ready, 1);

    // Key load, second request during the shift is ignored
    load_key(32'hDEADBEEF);
    repeat (5) @(negedge clk);
    check("busy_mid_shift", bus.key_busy, 1);
    load_key(32'h12345678);
    wait_quiet();
    check("cfg_queue_drained", q_cfg.size(), 0);

    // Key request 3 cycles into a tx word; next word held off until key done
    send_word(8'hC3, busy);
    repeat (2) @(negedge clk);
    load_key(32'hCAFE0123);
    send_word(8'h96, busy);
    check("tx_accept_after_key", busy, 0);
    wait_quiet();

    // RX reassembly of 0x3C with exact strobe timing
    bits3c = 8'h3C;
    for (int i = W - 1; i >= 0; i--) rx_send(bits3c[i]);
    rx_idle(1);
    @(negedge clk);
    check("rx_valid_not_early", bus.rx_valid, 0);
    @(negedge clk);
    check("rx_valid_strobe", bus.rx_valid, 1);
    check("rx_data_3c", bus.rx_data, 8'h3C);
    rx_idle(4);
    check("rx_3c_consumed", q_rx.size(), 0);

    // Partial word flushed, then 0x81
    for (int i = 0; i < 4; i++) rx_send(i[0]);
    rx_idle(4);
    rx_flush_pulse();
    rx_idle(3);
    bits81 = 8'h81;
    for (int i = W - 1; i >= 0; i--) rx_send(bits81[i]);
    rx_idle(6);
    check("rx_81_consumed", q_rx.size(), 0);

    // Line bits during key load are dropped, not forwarded
    load_key($urandom);
    begin
      int f0, d0;
      f0 = got_fwd; d0 = got_drop;
      for (int i = 0; i < 3; i++) rx_send(1'b1);
      rx_idle(3);
      check("rx_en_stays_low", got_fwd - f0, 0);
      check("rx_drop_pulses", got_drop - d0, 3);
    end
    wait_quiet();

    // Randomised concurrent traffic
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send_word(8'($urandom), busy);
        end
      end
      begin
        for (int i = 0; i < 200; i++) begin
          rx_send(1'($urandom));
          rx_idle($urandom_range(0, 2));
        end
        rx_idle(1);
      end
      begin
        for (int i = 0; i < 3; i++) begin
          repeat ($urandom_range(20, 120)) @(negedge clk);
          load_key($urandom);
        end
      end
    join
    rx_idle(5);
    rx_flush_pulse();
    rx_idle(4);
    wait_quiet();
    check("rx_queue_empty", q_rx.size(), 0);
    check("tx_queue_empty", q_tx.size(), 0);
    check("cfg_queue_empty", q_cfg.size(), 0);
    check("drop_count", got_drop, exp_drop);
    check("fwd_count", got_fwd, exp_fwd);

    // Reset in the middle of a tx word
    send_word(8'h5A, busy);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    q_tx.delete();
    m_bits.delete();
    repeat (2) @(negedge clk);
    check("no_residual_tx_en", bus.tx_en, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("tx_ready_after_rereset", bus.tx_ready, 1);
    send_word(8'h3C, busy);
    wait_quiet();
    check("tx_queue_after_reset", q_tx.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
